// File: rtl/bcd_pkg.sv
// Shared types for the BCD stopwatch: digit type, decade limit and controller states.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_e;
endpackage

// File: rtl/bcd_digit.sv
// One decade counter; co is combinational so a whole chain ripples in a single edge.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output bcd_digit_t q,
  output logic       co
);
  assign co = inc & (q == BCD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= (q == BCD_MAX) ? '0 : q + 4'd1;
  end
endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: start/stop/clear FSM, tick prescaler and an NDIG-digit BCD chain.
// Optional lap hold of the display value is enabled by defining LAP_HOLD_EN.
module bcd_stopwatch_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 10,
  parameter int WRAP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clr,
  input  logic              lap,
  output logic [4*NDIG-1:0] count,
  output logic [4*NDIG-1:0] disp,
  output logic              running,
  output logic              done,
  output logic              ovf
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  sw_state_e       state, nxt;
  logic [PW-1:0]   presc;
  logic [NDIG:0]   carry;
  logic [NDIG-1:0] dig9;
  logic            all9, tick, sat;

  // A stop on the tick edge wins: the tick is dropped and the prescaler holds.
  assign tick = (state == RUN) && !clr && !stop && (presc == PLAST);
  assign all9 = &dig9;
  assign sat  = (WRAP == 0) && all9;
  assign carry[0] = tick && !sat;

  genvar i;
  generate
    for (i = 0; i < NDIG; i++) begin : g_dig
      bcd_digit u_dig (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (carry[i]),
        .q   (count[4*i +: 4]),
        .co  (carry[i+1])
      );
      assign dig9[i] = (count[4*i +: 4] == BCD_MAX);
    end
  endgenerate

  always_comb begin
    nxt = state;
    if (clr) nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (!stop && start) nxt = RUN;
        RUN:     if (stop) nxt = PAUSE;
                 else if (tick && sat) nxt = DONE;
        PAUSE:   if (!stop && start) nxt = RUN;
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= nxt;
      ovf   <= tick && all9;
      if (clr) presc <= '0;
      else if (state == RUN && !stop) presc <= (presc == PLAST) ? '0 : presc + PW'(1);
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

`ifdef LAP_HOLD_EN
  logic              hold;
  logic [4*NDIG-1:0] lap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold  <= 1'b0;
      lap_q <= '0;
    end else if (clr) begin
      hold  <= 1'b0;
      lap_q <= '0;
    end else if (lap && (state == RUN || state == PAUSE)) begin
      hold <= !hold;
      if (!hold) lap_q <= count;
    end
  end

  assign disp = hold ? lap_q : count;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp = count;
`endif
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl (NDIG=2, PRESCALE=4): wrapping and saturating instances share stimulus.
module tb_bcd_stopwatch_ctrl;
`ifdef LAP_HOLD_EN
  localparam bit LAPEN = 1'b1;
`else
  localparam bit LAPEN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, clr = 1'b0, lap = 1'b0;
  logic [7:0] cnt1, dsp1, cnt0, dsp0;
  logic run1, dn1, ov1, run0, dn0, ov0;
  int checks = 0, errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.NDIG(2), .PRESCALE(4), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .lap(lap),
    .count(cnt1), .disp(dsp1), .running(run1), .done(dn1), .ovf(ov1));

  bcd_stopwatch_ctrl #(.NDIG(2), .PRESCALE(4), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .lap(lap),
    .count(cnt0), .disp(dsp0), .running(run0), .done(dn0), .ovf(ov0));

  typedef struct {
    string      nm;
    logic       s, p, c, l;
    int         idle;
    logic [7:0] c1; logic r1, d1, o1;
    logic [7:0] c0; logic r0, d0, o0;
    logic [7:0] dsp;
  } vec_t;

  vec_t vt[$];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

  // Every sampled count must be valid BCD, including mid-carry cycles.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("bcd_digits_w", {7'd0, bcd_ok(cnt1)}, 8'd1);
      chk("bcd_digits_s", {7'd0, bcd_ok(cnt0)}, 8'd1);
    end
  end

  function automatic vec_t mk(input string nm, input logic s, p, c, l, input int idle,
                              input logic [7:0] cv, input logic r, d, o);
    vec_t v;
    v.nm = nm; v.s = s; v.p = p; v.c = c; v.l = l; v.idle = idle;
    v.c1 = cv; v.r1 = r; v.d1 = d; v.o1 = o;
    v.c0 = cv; v.r0 = r; v.d0 = d; v.o0 = o;
    v.dsp = cv;
    return v;
  endfunction

  task automatic step(input logic s, p, c, l);
    start = s; stop = p; clr = c; lap = l;
    @(posedge clk); #1;
    start = 0; stop = 0; clr = 0; lap = 0;
  endtask

  initial begin
    vec_t v, e;

    //          name         s p c l idle  cnt    run dn ov
    vt.push_back(mk("idle_hold", 0,0,0,0,  0, 8'h00, 0, 0, 0));
    vt.push_back(mk("start",     1,0,0,0,  0, 8'h00, 1, 0, 0));
    vt.push_back(mk("presc3",    0,0,0,0,  2, 8'h00, 1, 0, 0));
    vt.push_back(mk("tick1",     0,0,0,0,  0, 8'h01, 1, 0, 0));
    vt.push_back(mk("cascade10", 0,0,0,0, 35, 8'h10, 1, 0, 0));
    vt.push_back(mk("run23",     0,0,0,0, 52, 8'h23, 1, 0, 0));
    vt.push_back(mk("pause23",   0,1,0,0, 19, 8'h23, 0, 0, 0));
    vt.push_back(mk("resume",    1,0,0,0,  0, 8'h23, 1, 0, 0));
    vt.push_back(mk("partial",   0,0,0,0,  1, 8'h23, 1, 0, 0));
    vt.push_back(mk("resume24",  0,0,0,0,  0, 8'h24, 1, 0, 0));
    vt.push_back(mk("pre_stop",  0,0,0,0,  2, 8'h24, 1, 0, 0));
    vt.push_back(mk("stop_tick", 0,1,0,0,  0, 8'h24, 0, 0, 0));
    vt.push_back(mk("restart",   1,0,0,0,  0, 8'h24, 1, 0, 0));
    vt.push_back(mk("held_tick", 0,0,0,0,  0, 8'h25, 1, 0, 0));
    vt.push_back(mk("prio_clr",  1,1,1,0,  0, 8'h00, 0, 0, 0));
    vt.push_back(mk("start2",    1,0,0,0,  0, 8'h00, 1, 0, 0));
    vt.push_back(mk("reach99",   0,0,0,0,395, 8'h99, 1, 0, 0));
    vt.push_back(mk("at99",      0,0,0,0,  2, 8'h99, 1, 0, 0));
    v = mk("terminal",           0,0,0,0,  0, 8'h00, 1, 0, 1);
    v.c0 = 8'h99; v.r0 = 0; v.d0 = 1; v.o0 = 1;
    vt.push_back(v);
    v = mk("ovf_pulse",          0,0,0,0,  0, 8'h00, 1, 0, 0);
    v.c0 = 8'h99; v.r0 = 0; v.d0 = 1; v.o0 = 0;
    vt.push_back(v);
    v = mk("done_ign_start",     1,0,0,0,  0, 8'h00, 1, 0, 0);
    v.c0 = 8'h99; v.r0 = 0; v.d0 = 1; v.o0 = 0;
    vt.push_back(v);
    vt.push_back(mk("clr_done",  0,0,1,0,  0, 8'h00, 0, 0, 0));
    vt.push_back(mk("start3",    1,0,0,0,  0, 8'h00, 1, 0, 0));
    vt.push_back(mk("run15",     0,0,0,0, 59, 8'h15, 1, 0, 0));
    vt.push_back(mk("lap15",     0,0,0,0,  0, 8'h15, 1, 0, 0));
    vt[$].l = 1;
    v = mk("lap_frozen",         0,0,0,0, 18, 8'h20, 1, 0, 0);
    v.dsp = LAPEN ? 8'h15 : 8'h20;
    vt.push_back(v);
    vt.push_back(mk("lap_release",0,0,0,1, 0, 8'h20, 1, 0, 0));
    vt.push_back(mk("lap_track", 0,0,0,0,  3, 8'h21, 1, 0, 0));
    vt.push_back(mk("clr_lap",   0,0,1,0,  0, 8'h00, 0, 0, 0));
    vt.push_back(mk("lap_idle",  0,0,0,1,  0, 8'h00, 0, 0, 0));
    vt.push_back(mk("after_lap", 1,0,0,0,  4, 8'h01, 1, 0, 0));

    // Reset is asynchronous: outputs are cleared before any clock edge.
    #2;
    chk("rst_count", cnt1, 8'h00);
    chk("rst_disp",  dsp1, 8'h00);
    chk("rst_flags", {5'd0, run1, dn1, ov1}, 8'h00);
    chk("rst_flags_s", {5'd0, run0, dn0, ov0}, 8'h00);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    foreach (vt[k]) begin
      v = vt[k];
      step(v.s, v.p, v.c, v.l);
      for (int n = 0; n < v.idle; n++) step(0, 0, 0, 0);
      sb.push_back(v);
      e = sb.pop_front();
      chk({e.nm, "/cnt_w"},  cnt1, e.c1);
      chk({e.nm, "/flg_w"},  {5'd0, run1, dn1, ov1}, {5'd0, e.r1, e.d1, e.o1});
      chk({e.nm, "/disp_w"}, dsp1, e.dsp);
      chk({e.nm, "/cnt_s"},  cnt0, e.c0);
      chk({e.nm, "/flg_s"},  {5'd0, run0, dn0, ov0}, {5'd0, e.r0, e.d0, e.o0});
    end

    // Asynchronous reset mid-RUN, asserted between clock edges.
    for (int n = 0; n < 5; n++) step(0, 0, 0, 0);
    chk("pre_arst_cnt", cnt1, 8'h02);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt_w", cnt1, 8'h00);
    chk("arst_cnt_s", cnt0, 8'h00);
    chk("arst_run",   {7'd0, run1}, 8'h00);
    #1 rst = 1'b0;
    step(0, 0, 0, 0);
    chk("post_arst_idle", {6'd0, run1, dn1}, 8'h00);
    chk("post_arst_cnt",  cnt1, 8'h00);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
